// File: rtl/mdio_master.sv
// mdio_master: IEEE 802.3 Clause 22 / Clause 45 MDIO management master.
// Serialises one host register transaction at a time onto MDC/MDIO.
module mdio_master #(
    parameter int CLK_DIV      = 4,
    parameter int PREAMBLE_LEN = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_cl45,
    input  logic [1:0]  req_op,
    input  logic [4:0]  req_phyad,
    input  logic [4:0]  req_regad,
    input  logic [15:0] req_data,
    output logic        rsp_valid,
    output logic [15:0] rsp_data,
    output logic        rsp_error,
    output logic        mdc,
    output logic        mdio_out,
    output logic        mdio_oe,
    input  logic        mdio_in
);

    localparam int CW = $clog2(2 * CLK_DIV);
    localparam logic [CW-1:0] LOW_END = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] BIT_END = CW'(2 * CLK_DIV - 1);
    localparam logic [4:0] PRE_LAST =
        (PREAMBLE_LEN > 0) ? 5'(PREAMBLE_LEN - 1) : 5'd0;

    typedef enum logic [3:0] {
        S_IDLE,
        S_PRE,
        S_ST,
        S_OP,
        S_PHY,
        S_REG,
        S_TA,
        S_DATA,
        S_DONE
    } state_e;

    state_e          state_q;
    state_e          state_d;
    logic [4:0]      bit_q;
    logic [4:0]      bit_d;
    logic [CW-1:0]   cyc_q;
    logic [31:0]     fr_q;
    logic            rd_q;
    logic            err_q;
    logic [15:0]     sh_q;
    logic            ready_q;
    logic            rsp_valid_q;
    logic [15:0]     rsp_data_q;
    logic            rsp_error_q;
    logic            mdc_q;
    logic            out_q;
    logic            oe_q;

    logic            out_d;
    logic            oe_d;
    logic [4:0]      last_bit;
    logic [4:0]      base;
    logic [4:0]      pos;
    logic            illegal;

    assign req_ready = ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_error = rsp_error_q;
    assign mdc       = mdc_q;
    assign mdio_out  = out_q;
    assign mdio_oe   = oe_q;

    assign illegal = ~req_cl45 & (req_op == 2'b00 || req_op == 2'b11);

    // Next bit of the frame: field/bit position plus the pin values for it.
    always_comb begin
        last_bit = 5'd0;
        state_d  = state_q;
        bit_d    = bit_q + 5'd1;
        base     = 5'd0;
        oe_d     = 1'b0;
        out_d    = 1'b1;

        unique case (state_q)
            S_PRE:             last_bit = PRE_LAST;
            S_ST, S_OP, S_TA:  last_bit = 5'd1;
            S_PHY, S_REG:      last_bit = 5'd4;
            S_DATA:            last_bit = 5'd15;
            default:           last_bit = 5'd0;
        endcase

        if (bit_q == last_bit) begin
            bit_d = 5'd0;
            unique case (state_q)
                S_PRE:   state_d = S_ST;
                S_ST:    state_d = S_OP;
                S_OP:    state_d = S_PHY;
                S_PHY:   state_d = S_REG;
                S_REG:   state_d = S_TA;
                S_TA:    state_d = S_DATA;
                S_DATA:  state_d = S_DONE;
                default: state_d = state_q;
            endcase
        end

        unique case (state_d)
            S_OP:    base = 5'd2;
            S_PHY:   base = 5'd4;
            S_REG:   base = 5'd9;
            S_TA:    base = 5'd14;
            S_DATA:  base = 5'd16;
            default: base = 5'd0;
        endcase
        pos = base + bit_d;

        unique case (1'b1)
            state_d == S_PRE,
            state_d == S_ST,
            state_d == S_OP,
            state_d == S_PHY,
            state_d == S_REG:  oe_d = 1'b1;
            state_d == S_TA,
            state_d == S_DATA: oe_d = ~rd_q;
            default:           oe_d = 1'b0;
        endcase

        if (oe_d && state_d != S_PRE) begin
            out_d = fr_q[5'd31 - pos];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            bit_q       <= 5'd0;
            cyc_q       <= '0;
            fr_q        <= 32'd0;
            rd_q        <= 1'b0;
            err_q       <= 1'b0;
            sh_q        <= 16'd0;
            ready_q     <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 16'd0;
            rsp_error_q <= 1'b0;
            mdc_q       <= 1'b0;
            out_q       <= 1'b1;
            oe_q        <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        ready_q <= 1'b0;
                        cyc_q   <= '0;
                        bit_q   <= 5'd0;
                        rd_q    <= req_op[1];
                        err_q   <= 1'b0;
                        fr_q    <= {1'b0, ~req_cl45, req_op, req_phyad,
                                    req_regad, 2'b10, req_data};
                        if (illegal) begin
                            state_q     <= S_DONE;
                            rsp_valid_q <= 1'b1;
                            rsp_data_q  <= 16'd0;
                            rsp_error_q <= 1'b1;
                        end else begin
                            // ST always opens with a 0 bit for both clauses
                            state_q <= (PREAMBLE_LEN > 0) ? S_PRE : S_ST;
                            oe_q    <= 1'b1;
                            out_q   <= (PREAMBLE_LEN > 0) ? 1'b1 : 1'b0;
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b1;
                end
                default: begin
                    cyc_q <= cyc_q + CW'(1);
                    if (cyc_q == LOW_END) begin
                        mdc_q <= 1'b1;
                        if (rd_q && state_q == S_TA && bit_q == 5'd1) begin
                            err_q <= mdio_in;
                        end
                        if (rd_q && state_q == S_DATA) begin
                            sh_q <= {sh_q[14:0], mdio_in};
                        end
                    end else if (cyc_q == BIT_END) begin
                        mdc_q   <= 1'b0;
                        cyc_q   <= '0;
                        state_q <= state_d;
                        bit_q   <= bit_d;
                        if (state_d == S_DONE) begin
                            rsp_valid_q <= 1'b1;
                            rsp_data_q  <= rd_q ? sh_q : 16'd0;
                            rsp_error_q <= rd_q & err_q;
                            oe_q        <= 1'b0;
                            out_q       <= 1'b1;
                        end else begin
                            oe_q  <= oe_d;
                            out_q <= out_d;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdio_master.sv
// Self-checking bench for mdio_master: frame-level model with per-cycle
// comparison, plus literal expectations for the directed transactions.
module tb_mdio_master;

    localparam int D = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        sel;
    logic        req_cl45;
    logic [1:0]  req_op;
    logic [4:0]  req_phyad;
    logic [4:0]  req_regad;
    logic [15:0] req_data;
    logic        mdio_in = 1'b1;

    logic        rdy_a, vld_a, err_a, mdc_a, out_a, oe_a;
    logic [15:0] dat_a;
    logic        rdy_b, vld_b, err_b, mdc_b, out_b, oe_b;
    logic [15:0] dat_b;
    logic        valid_a, valid_b;

    assign valid_a = req_valid & ~sel;
    assign valid_b = req_valid & sel;

    mdio_master #(.CLK_DIV(D), .PREAMBLE_LEN(32)) dut (
        .clk(clk), .reset(reset),
        .req_valid(valid_a), .req_ready(rdy_a),
        .req_cl45(req_cl45), .req_op(req_op),
        .req_phyad(req_phyad), .req_regad(req_regad),
        .req_data(req_data),
        .rsp_valid(vld_a), .rsp_data(dat_a), .rsp_error(err_a),
        .mdc(mdc_a), .mdio_out(out_a), .mdio_oe(oe_a),
        .mdio_in(mdio_in)
    );

    mdio_master #(.CLK_DIV(D), .PREAMBLE_LEN(0)) dut0 (
        .clk(clk), .reset(reset),
        .req_valid(valid_b), .req_ready(rdy_b),
        .req_cl45(req_cl45), .req_op(req_op),
        .req_phyad(req_phyad), .req_regad(req_regad),
        .req_data(req_data),
        .rsp_valid(vld_b), .rsp_data(dat_b), .rsp_error(err_b),
        .mdc(mdc_b), .mdio_out(out_b), .mdio_oe(oe_b),
        .mdio_in(mdio_in)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Transaction model: expected per-bit pin values and response.
    bit          mf_out [64];
    bit          mf_oe  [64];
    int          mN = 0;
    int          mP = 32;
    int          t_acc = 0;
    bit          active = 0;
    bit          m_rd = 0;
    bit          phy_ta = 1;
    bit [15:0]   phy_data = 16'hFFFF;
    logic [16:0] cur_rsp = 17'd0;
    logic [16:0] prev_rsp = 17'd0;

    int          got_abs = -1;
    logic [16:0] got_rsp = 17'd0;
    int          rise_total = 0;
    logic        mdc_prev = 1'b0;

    task automatic chk(input string nm, input logic [31:0] a,
                       input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", nm, a, e);
        end
    endtask

    function automatic bit model_busy();
        return active && (cyc - t_acc + 1) <= mN * 2 * D + 1;
    endfunction

    function automatic logic [31:0] model_word();
        logic [31:0] w = 32'd0;
        for (int i = 0; i < 32; i++) w = {w[30:0], mf_out[mP + i]};
        return w;
    endfunction

    // PHY: drives the addressed bit value for the whole bit period.
    always @(negedge clk) begin : phy
        int k, j;
        logic v;
        k = cyc - t_acc + 1;
        v = 1'b1;
        if (active && m_rd && k >= 1 && k <= mN * 2 * D) begin
            j = (k - 1) / (2 * D);
            if (j == mP + 15) v = phy_ta;
            else if (j >= mP + 16) v = phy_data[15 - (j - mP - 16)];
        end
        mdio_in = v;
    end

    // Per-cycle comparison of the selected DUT against the model.
    always @(negedge clk) begin : cmp
        int k, n2, j, ph;
        logic a_rdy, a_vld, a_mdc, a_oe, a_out;
        logic [16:0] a_rsp;
        logic e_rdy, e_vld, e_mdc, e_oe, e_out;
        logic [16:0] e_rsp;
        if (sel) begin
            a_rdy = rdy_b; a_vld = vld_b; a_mdc = mdc_b;
            a_oe = oe_b; a_out = out_b; a_rsp = {err_b, dat_b};
        end else begin
            a_rdy = rdy_a; a_vld = vld_a; a_mdc = mdc_a;
            a_oe = oe_a; a_out = out_a; a_rsp = {err_a, dat_a};
        end
        k  = cyc - t_acc + 1;
        n2 = mN * 2 * D;
        e_rdy = 1'b1; e_vld = 1'b0; e_mdc = 1'b0;
        e_oe = 1'b0; e_out = 1'b1; e_rsp = prev_rsp;
        if (active && k >= 1) begin
            if (k <= n2) begin
                j  = (k - 1) / (2 * D);
                ph = (k - 1) % (2 * D);
                e_rdy = 1'b0;
                e_mdc = (ph >= D);
                e_oe  = mf_oe[j];
                e_out = mf_out[j];
            end else begin
                e_rsp = cur_rsp;
                if (k == n2 + 1) begin
                    e_rdy = 1'b0;
                    e_vld = 1'b1;
                end
            end
        end
        checks++;
        if ({a_rdy, a_vld, a_mdc, a_oe, a_out, a_rsp} !==
            {e_rdy, e_vld, e_mdc, e_oe, e_out, e_rsp}) begin
            errors++;
            $display("FAIL cycle k=%0d act rdy%b vld%b mdc%b oe%b out%b rsp=%h exp rdy%b vld%b mdc%b oe%b out%b rsp=%h",
                     k, a_rdy, a_vld, a_mdc, a_oe, a_out, a_rsp,
                     e_rdy, e_vld, e_mdc, e_oe, e_out, e_rsp);
        end
        if (a_vld === 1'b1) begin
            got_abs = cyc;
            got_rsp = a_rsp;
        end
        if (a_mdc === 1'b1 && mdc_prev === 1'b0) rise_total++;
        mdc_prev = a_mdc;
    end

    task automatic send(input bit s, input bit cl45, input bit [1:0] op,
                        input bit [4:0] phy, input bit [4:0] rg,
                        input bit [15:0] d, input bit pta,
                        input bit [15:0] pd);
        int budget, n;
        bit ill, rd;
        bit [13:0] hd;
        bit [17:0] tl;
        budget = 0;
        @(negedge clk);
        while (model_busy() && budget < 5000) begin
            @(negedge clk);
            budget++;
        end
        if (budget >= 5000) chk("send_wait", 32'd1, 32'd0);
        #1;
        ill = !cl45 && (op == 2'b00 || op == 2'b11);
        rd  = op[1] && !ill;
        mP  = s ? 0 : 32;
        n   = 0;
        for (int i = 0; i < mP; i++) begin
            mf_out[n] = 1'b1; mf_oe[n] = 1'b1; n++;
        end
        hd = {(cl45 ? 2'b00 : 2'b01), op, phy, rg};
        for (int i = 13; i >= 0; i--) begin
            mf_out[n] = hd[i]; mf_oe[n] = 1'b1; n++;
        end
        tl = {2'b10, d};
        for (int i = 17; i >= 0; i--) begin
            mf_out[n] = rd ? 1'b1 : tl[i]; mf_oe[n] = !rd; n++;
        end
        if (active) prev_rsp = cur_rsp;
        mN       = ill ? 0 : n;
        m_rd     = rd;
        phy_ta   = pta;
        phy_data = pd;
        cur_rsp  = ill ? {1'b1, 16'h0} : (rd ? {pta, pd} : 17'd0);
        sel       = s;
        req_cl45  = cl45;
        req_op    = op;
        req_phyad = phy;
        req_regad = rg;
        req_data  = d;
        req_valid = 1'b1;
        t_acc     = cyc + 1;
        active    = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_done();
        int budget = 0;
        @(negedge clk);
        while (model_busy() && budget < 5000) begin
            @(negedge clk);
            budget++;
        end
        if (budget >= 5000) chk("done_wait", 32'd1, 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0, t1;
        reset = 1'b1; req_valid = 1'b0; sel = 1'b0; req_cl45 = 1'b0;
        req_op = 2'b00; req_phyad = 5'd0; req_regad = 5'd0; req_data = 16'd0;
        #2;
        chk("reset_state", {10'd0, rdy_a, vld_a, mdc_a, oe_a, out_a, err_a, dat_a},
            {10'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0});
        repeat (3) @(negedge clk);
        #1 reset = 1'b0;

        // Cl22 write
        r0 = rise_total;
        send(0, 0, 2'b01, 5'h01, 5'h00, 16'hABCD, 1, 16'hFFFF);
        chk("wr_frame", model_word(), 32'h5082ABCD);
        wait_done();
        chk("wr_rsp_cycle", got_abs - t_acc + 1, 32'd513);
        chk("wr_rsp", {15'd0, got_rsp}, 32'd0);
        chk("wr_mdc_rises", rise_total - r0, 32'd64);

        // Cl22 read with PHY answering FEED
        send(0, 0, 2'b10, 5'h01, 5'h00, 16'h0000, 0, 16'hFEED);
        chk("rd_frame", model_word(), 32'h6083FFFF);
        wait_done();
        chk("rd_rsp", {15'd0, got_rsp}, {15'd0, 1'b0, 16'hFEED});

        // Cl22 read with no PHY present
        send(0, 0, 2'b10, 5'h07, 5'h02, 16'h0000, 1, 16'hFFFF);
        wait_done();
        chk("nophy_rsp", {15'd0, got_rsp}, {15'd0, 1'b1, 16'hFFFF});

        // Cl45 address then read-increment, back to back
        send(0, 1, 2'b00, 5'h02, 5'h01, 16'h0010, 1, 16'hFFFF);
        chk("c45a_frame", model_word(), 32'h01060010);
        t1 = t_acc;
        send(0, 1, 2'b10, 5'h02, 5'h01, 16'h0000, 0, 16'hCAFE);
        chk("c45_gap", t_acc - t1, 32'd514);
        chk("c45r_frame", model_word(), 32'h2107FFFF);
        wait_done();
        chk("c45r_rsp", {15'd0, got_rsp}, {15'd0, 1'b0, 16'hCAFE});

        // Illegal Cl22 op
        r0 = rise_total;
        send(0, 0, 2'b11, 5'h01, 5'h01, 16'h1234, 1, 16'hFFFF);
        wait_done();
        chk("ill_rsp_cycle", got_abs - t_acc + 1, 32'd1);
        chk("ill_rsp", {15'd0, got_rsp}, {15'd0, 1'b1, 16'h0});
        chk("ill_mdc_rises", rise_total - r0, 32'd0);

        // Reset during DATA of a write
        send(0, 0, 2'b01, 5'h1F, 5'h1E, 16'h1234, 1, 16'hFFFF);
        while ((cyc - t_acc + 1) < 397 && (cyc - t_acc + 1) < 600) @(negedge clk);
        @(posedge clk);
        #3;
        chk("pre_rst_mdc_oe", {30'd0, mdc_a, oe_a}, 32'd3);
        active = 1'b0;
        prev_rsp = 17'd0;
        reset = 1'b1;
        #1;
        chk("rst_mdc_oe", {30'd0, mdc_a, oe_a}, 32'd0);
        repeat (3) @(negedge clk);
        #1 reset = 1'b0;
        send(0, 0, 2'b01, 5'h03, 5'h04, 16'h55AA, 1, 16'hFFFF);
        wait_done();
        chk("post_rst_cycle", got_abs - t_acc + 1, 32'd513);

        // No-preamble instance
        send(1, 0, 2'b01, 5'h03, 5'h04, 16'h55AA, 1, 16'hFFFF);
        chk("np_frame", model_word(), 32'h519255AA);
        wait_done();
        chk("np_rsp_cycle", got_abs - t_acc + 1, 32'd257);

        repeat (4) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
